// File: rtl/dft_mac_engine.sv
`default_nettype none
// ============================================================================
// Module      : dft_mac_engine
// Description : Direct O(N^2) DFT, one complex MAC per cycle, with a sample
//               buffer, an external twiddle ROM and a streamed result port.
// Revision    : 1.0 - initial release
// ============================================================================
module dft_mac_engine #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int ACC_W  = 2*DATA_W + ADDR_W
) (
    input  logic                clk,
    input  logic                n_Reset,
    input  logic                i_start,
    input  logic                i_inverse,
    input  logic [ADDR_W-1:0]   i_samp_number,
    input  logic [2*DATA_W-1:0] s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic [ADDR_W-1:0]   tw_addr,
    input  logic [2*DATA_W-1:0] tw_data,
    output logic [2*DATA_W-1:0] m_data,
    output logic [ADDR_W-1:0]   m_index,
    output logic                m_last,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                o_busy,
    output logic                o_done
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_OUTPUT  = 2'd3
    } state_t;

    localparam int c_depth = 1 << ADDR_W;
    localparam logic signed [ACC_W:0] c_half =
        {{(ACC_W-DATA_W+2){1'b0}}, 1'b1, {(DATA_W-2){1'b0}}};
    localparam logic signed [ACC_W:0] c_sat_max =
        {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] c_sat_min = ~c_sat_max;

    state_t                     r_state;
    logic [ADDR_W-1:0]          r_len;
    logic                       r_inv;
    logic [ADDR_W:0]            r_cnt;
    logic [ADDR_W-1:0]          r_k;
    logic [ADDR_W-1:0]          r_idx;
    logic                       r_s1_v;
    logic signed [DATA_W-1:0]   r_xr;
    logic signed [DATA_W-1:0]   r_xi;
    logic signed [DATA_W-1:0]   r_c;
    logic signed [DATA_W-1:0]   r_s;
    logic signed [ACC_W-1:0]    r_acc_re;
    logic signed [ACC_W-1:0]    r_acc_im;
    logic [2*DATA_W-1:0]        r_m_data;
    logic [ADDR_W-1:0]          r_m_index;
    logic                       r_m_last;
    logic                       r_m_valid;
    logic                       r_done;
    logic [2*DATA_W-1:0]        r_buf [0:c_depth-1];

    logic [ADDR_W:0]            w_len_ext;
    logic                       w_issue;
    logic                       w_flush;
    logic [ADDR_W:0]            w_idx_sum;
    logic [ADDR_W-1:0]          w_idx_next;
    logic [2*DATA_W-1:0]        w_buf_rd;
    logic signed [2*DATA_W-1:0] w_xr_c;
    logic signed [2*DATA_W-1:0] w_xi_s;
    logic signed [2*DATA_W-1:0] w_xi_c;
    logic signed [2*DATA_W-1:0] w_xr_s;
    logic signed [ACC_W-1:0]    w_d_re;
    logic signed [ACC_W-1:0]    w_d_im;

    function automatic logic signed [ACC_W-1:0] f_ext(input logic signed [2*DATA_W-1:0] p);
        return {{(ACC_W-2*DATA_W){p[2*DATA_W-1]}}, p};
    endfunction

    function automatic logic [DATA_W-1:0] f_round_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W:0] v;
        v = $signed({acc[ACC_W-1], acc}) + c_half;
        v = v >>> (DATA_W-1);
        if (v > c_sat_max)
            return c_sat_max[DATA_W-1:0];
        else if (v < c_sat_min)
            return c_sat_min[DATA_W-1:0];
        else
            return v[DATA_W-1:0];
    endfunction

    assign w_len_ext = {1'b0, r_len};
    assign w_issue   = (r_cnt < w_len_ext);
    assign w_flush   = (r_cnt == (w_len_ext + 1'b1));

    // idx = (n*k) mod N tracked by repeated addition; idx,k < N so one wrap suffices
    assign w_idx_sum  = {1'b0, r_idx} + {1'b0, r_k};
    assign w_idx_next = (w_idx_sum >= w_len_ext) ? (w_idx_sum[ADDR_W-1:0] - r_len)
                                                 : w_idx_sum[ADDR_W-1:0];

    assign w_buf_rd = r_buf[r_cnt[ADDR_W-1:0]];

    assign w_xr_c = r_xr * r_c;
    assign w_xi_s = r_xi * r_s;
    assign w_xi_c = r_xi * r_c;
    assign w_xr_s = r_xr * r_s;
    assign w_d_re = r_inv ? (f_ext(w_xr_c) - f_ext(w_xi_s)) : (f_ext(w_xr_c) + f_ext(w_xi_s));
    assign w_d_im = r_inv ? (f_ext(w_xi_c) + f_ext(w_xr_s)) : (f_ext(w_xi_c) - f_ext(w_xr_s));

    always_ff @(posedge clk) begin
        if (r_state == ST_LOAD && s_valid)
            r_buf[r_cnt[ADDR_W-1:0]] <= s_data;
    end

    always_ff @(posedge clk or negedge n_Reset) begin
        if (!n_Reset) begin
            r_state   <= ST_IDLE;
            r_len     <= '0;
            r_inv     <= 1'b0;
            r_cnt     <= '0;
            r_k       <= '0;
            r_idx     <= '0;
            r_s1_v    <= 1'b0;
            r_xr      <= '0;
            r_xi      <= '0;
            r_c       <= '0;
            r_s       <= '0;
            r_acc_re  <= '0;
            r_acc_im  <= '0;
            r_m_data  <= '0;
            r_m_index <= '0;
            r_m_last  <= 1'b0;
            r_m_valid <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start && (i_samp_number != '0)) begin
                        r_len   <= i_samp_number;
                        r_inv   <= i_inverse;
                        r_cnt   <= '0;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (s_valid) begin
                        if (r_cnt[ADDR_W-1:0] == (r_len - 1'b1)) begin
                            r_cnt    <= '0;
                            r_k      <= '0;
                            r_idx    <= '0;
                            r_s1_v   <= 1'b0;
                            r_acc_re <= '0;
                            r_acc_im <= '0;
                            r_state  <= ST_COMPUTE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_COMPUTE: begin
                    r_cnt  <= r_cnt + 1'b1;
                    r_s1_v <= w_issue;
                    if (w_issue) begin
                        r_xr  <= w_buf_rd[2*DATA_W-1:DATA_W];
                        r_xi  <= w_buf_rd[DATA_W-1:0];
                        r_c   <= tw_data[2*DATA_W-1:DATA_W];
                        r_s   <= tw_data[DATA_W-1:0];
                        r_idx <= w_idx_next;
                    end
                    if (r_s1_v) begin
                        r_acc_re <= r_acc_re + w_d_re;
                        r_acc_im <= r_acc_im + w_d_im;
                    end
                    // Pipeline drained: publish the bin two cycles after the last issue
                    if (w_flush) begin
                        r_m_data  <= {f_round_sat(r_acc_re), f_round_sat(r_acc_im)};
                        r_m_index <= r_k;
                        r_m_last  <= (r_k == (r_len - 1'b1));
                        r_m_valid <= 1'b1;
                        r_state   <= ST_OUTPUT;
                    end
                end
                ST_OUTPUT: begin
                    if (r_m_valid && m_ready) begin
                        r_m_valid <= 1'b0;
                        if (r_m_last) begin
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_k      <= r_k + 1'b1;
                            r_cnt    <= '0;
                            r_idx    <= '0;
                            r_s1_v   <= 1'b0;
                            r_acc_re <= '0;
                            r_acc_im <= '0;
                            r_state  <= ST_COMPUTE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s_ready = (r_state == ST_LOAD);
    assign o_busy  = (r_state != ST_IDLE);
    assign tw_addr = r_idx;
    assign m_data  = r_m_data;
    assign m_index = r_m_index;
    assign m_last  = r_m_last;
    assign m_valid = r_m_valid;
    assign o_done  = r_done;

endmodule
`default_nettype wire
